mem_arbiter: RTL and testbench

Responder for both Core bus masters: the instruction bus (read-only) and the data bus (read/write). It arbitrates the two request streams onto one synchronous single-port RAM and returns data and a single-cycle ack to the requesting master. It sits between Core and the on-chip memory, and is the far end of Core's `*_m_access`/`*_m_ack` handshake.

---
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bus bundle between the Core masters, the arbiter and the
// on-chip single-port RAM.
//
// Signals:
//   instr_m_*  instruction bus (read-only): addr, access in; data_in, ack out
//   data_m_*   data bus (read/write): addr, data_out, access, wr_en, bytesel
//              in; data_in, ack out
//   ram_*      RAM port: cs, wr_en, addr, wdata, bytesel out; rdata in
//
// Modports:
//   slave   the arbiter side (responds to Core, drives the RAM)
//   master  the surrounding system (Core requests, RAM read data)
interface mem_arbiter_if;
   logic [18:0] instr_m_addr;
   logic [15:0] instr_m_data_in;
   logic        instr_m_access;
   logic        instr_m_ack;

   logic [18:0] data_m_addr;
   logic [15:0] data_m_data_in;
   logic [15:0] data_m_data_out;
   logic        data_m_access;
   logic        data_m_ack;
   logic        data_m_wr_en;
   logic [1:0]  data_m_bytesel;

   logic        ram_cs;
   logic        ram_wr_en;
   logic [18:0] ram_addr;
   logic [15:0] ram_wdata;
   logic [1:0]  ram_bytesel;
   logic [15:0] ram_rdata;

   modport slave (
      input  instr_m_addr, instr_m_access,
      input  data_m_addr, data_m_data_out, data_m_access, data_m_wr_en, data_m_bytesel,
      input  ram_rdata,
      output instr_m_data_in, instr_m_ack,
      output data_m_data_in, data_m_ack,
      output ram_cs, ram_wr_en, ram_addr, ram_wdata, ram_bytesel
   );

   modport master (
      output instr_m_addr, instr_m_access,
      output data_m_addr, data_m_data_out, data_m_access, data_m_wr_en, data_m_bytesel,
      output ram_rdata,
      input  instr_m_data_in, instr_m_ack,
      input  data_m_data_in, data_m_ack,
      input  ram_cs, ram_wr_en, ram_addr, ram_wdata, ram_bytesel
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- round-robin responder for the Core instruction and data
// buses, sharing one synchronous single-port RAM.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  asynchronous, active-low reset
//   bus    mem_arbiter_if.slave: Core request/ack handshakes and RAM port
//
// Parameter:
//   WAIT_STATES  extra RAM read-latency cycles between RAM select and ack (0..15)
//
// Sequence per transfer: IDLE (grant + latch) -> ACCESS (ram_cs) ->
// WAIT x WAIT_STATES -> ACK (one-cycle ack) -> IDLE.
module mem_arbiter #(
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

   // Counter load value; only reachable when WAIT_STATES > 0.
   localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   state_t      state_q;
   logic [3:0]  cnt_q;
   // Doubles as the current grant and the round-robin history (1 = data).
   logic        grant_data_q;
   logic        wr_q;
   logic        instr_ack_q;
   logic        data_ack_q;
   logic        ram_cs_q;
   logic        ram_wr_en_q;
   logic [18:0] ram_addr_q;
   logic [15:0] ram_wdata_q;
   logic [1:0]  ram_bytesel_q;

   logic        grant_data_d;
   logic        any_req;

   // Data wins when it is the only requester, or on a tie when instr was
   // granted last.
   assign any_req      = bus.instr_m_access | bus.data_m_access;
   assign grant_data_d = bus.data_m_access & (~bus.instr_m_access | ~grant_data_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         cnt_q         <= 4'd0;
         grant_data_q  <= 1'b0;
         wr_q          <= 1'b0;
         instr_ack_q   <= 1'b0;
         data_ack_q    <= 1'b0;
         ram_cs_q      <= 1'b0;
         ram_wr_en_q   <= 1'b0;
         ram_addr_q    <= '0;
         ram_wdata_q   <= '0;
         ram_bytesel_q <= '0;
      end else begin
         // RAM strobes and acks are single-cycle; default them low.
         ram_cs_q      <= 1'b0;
         ram_wr_en_q   <= 1'b0;
         ram_addr_q    <= '0;
         ram_wdata_q   <= '0;
         ram_bytesel_q <= '0;
         instr_ack_q   <= 1'b0;
         data_ack_q    <= 1'b0;

         case (state_q)
            IDLE: begin
               if (any_req) begin
                  grant_data_q <= grant_data_d;
                  ram_cs_q     <= 1'b1;
                  if (grant_data_d) begin
                     ram_wr_en_q   <= bus.data_m_wr_en;
                     ram_addr_q    <= bus.data_m_addr;
                     ram_wdata_q   <= bus.data_m_data_out;
                     ram_bytesel_q <= bus.data_m_bytesel;
                     wr_q          <= bus.data_m_wr_en;
                  end else begin
                     ram_addr_q    <= bus.instr_m_addr;
                     ram_bytesel_q <= 2'b11;
                     wr_q          <= 1'b0;
                  end
                  state_q <= ACCESS;
               end
            end

            ACCESS: begin
               if (WAIT_STATES > 0) begin
                  cnt_q   <= WAIT_INIT;
                  state_q <= WAIT;
               end else begin
                  instr_ack_q <= ~grant_data_q;
                  data_ack_q  <= grant_data_q;
                  state_q     <= ACK;
               end
            end

            WAIT: begin
               if (cnt_q == 4'd0) begin
                  instr_ack_q <= ~grant_data_q;
                  data_ack_q  <= grant_data_q;
                  state_q     <= ACK;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end

            ACK: begin
               state_q <= IDLE;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.instr_m_ack = instr_ack_q;
   assign bus.data_m_ack  = data_ack_q;
   assign bus.ram_cs      = ram_cs_q;
   assign bus.ram_wr_en   = ram_wr_en_q;
   assign bus.ram_addr    = ram_addr_q;
   assign bus.ram_wdata   = ram_wdata_q;
   assign bus.ram_bytesel = ram_bytesel_q;

   // Read data is passed straight through from the RAM during the ack cycle;
   // writes return zero.
   assign bus.instr_m_data_in = instr_ack_q ? bus.ram_rdata : 16'h0000;
   assign bus.data_m_data_in  = (data_ack_q && !wr_q) ? bus.ram_rdata : 16'h0000;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- scoreboard bench for mem_arbiter with WAIT_STATES=0
// (dut_a) and WAIT_STATES=3 (dut_b), each with its own behavioural RAM.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst_a_n;
   logic rst_b_n;

   always #5 clk = ~clk;

   mem_arbiter_if ifa ();
   mem_arbiter_if ifb ();

   mem_arbiter #(.WAIT_STATES(0)) dut_a (.clk(clk), .reset(rst_a_n), .bus(ifa.slave));
   mem_arbiter #(.WAIT_STATES(3)) dut_b (.clk(clk), .reset(rst_b_n), .bus(ifb.slave));

   // Synchronous RAM models: 1-cycle read, rdata held until the next select.
   logic [15:0] mem_a [0:524287];
   logic [15:0] mem_b [0:524287];
   logic [15:0] rdata_a = 16'h0000;
   logic [15:0] rdata_b = 16'h0000;

   always @(posedge clk) begin
      if (ifa.ram_cs) begin
         if (ifa.ram_wr_en) begin
            if (ifa.ram_bytesel[0]) mem_a[ifa.ram_addr][7:0]  <= ifa.ram_wdata[7:0];
            if (ifa.ram_bytesel[1]) mem_a[ifa.ram_addr][15:8] <= ifa.ram_wdata[15:8];
         end
         rdata_a <= mem_a[ifa.ram_addr];
      end
      if (ifb.ram_cs) begin
         if (ifb.ram_wr_en) begin
            if (ifb.ram_bytesel[0]) mem_b[ifb.ram_addr][7:0]  <= ifb.ram_wdata[7:0];
            if (ifb.ram_bytesel[1]) mem_b[ifb.ram_addr][15:8] <= ifb.ram_wdata[15:8];
         end
         rdata_b <= mem_b[ifb.ram_addr];
      end
   end

   assign ifa.ram_rdata = rdata_a;
   assign ifb.ram_rdata = rdata_b;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic        is_data;
      logic [15:0] rdata;
   } exp_t;

   exp_t sb_a[$];
   exp_t sb_b[$];
   int   stray_a = 0;
   int   stray_b = 0;

   // Scoreboard: every ack pops the oldest expected transfer.
   always @(negedge clk) begin
      exp_t e;
      if (ifa.instr_m_ack || ifa.data_m_ack) begin
         if (sb_a.size() == 0) begin
            check_eq("a_sb_pending", 32'(sb_a.size()), 32'd1);
         end else begin
            e = sb_a.pop_front();
            check_eq("a_grant", 32'({ifa.instr_m_ack, ifa.data_m_ack}), 32'({~e.is_data, e.is_data}));
            check_eq("a_rdata", 32'(e.is_data ? ifa.data_m_data_in : ifa.instr_m_data_in), 32'(e.rdata));
         end
      end
      if (ifb.instr_m_ack || ifb.data_m_ack) begin
         if (sb_b.size() == 0) begin
            check_eq("b_sb_pending", 32'(sb_b.size()), 32'd1);
         end else begin
            e = sb_b.pop_front();
            check_eq("b_grant", 32'({ifb.instr_m_ack, ifb.data_m_ack}), 32'({~e.is_data, e.is_data}));
            check_eq("b_rdata", 32'(e.is_data ? ifb.data_m_data_in : ifb.instr_m_data_in), 32'(e.rdata));
         end
      end
      if (!ifa.instr_m_ack && ifa.instr_m_data_in !== 16'h0) stray_a++;
      if (!ifa.data_m_ack  && ifa.data_m_data_in  !== 16'h0) stray_a++;
      if (!ifb.instr_m_ack && ifb.instr_m_data_in !== 16'h0) stray_b++;
      if (!ifb.data_m_ack  && ifb.data_m_data_in  !== 16'h0) stray_b++;
   end

   task automatic wait_ack_a(input int max, output int k);
      k = 0;
      while (!(ifa.instr_m_ack || ifa.data_m_ack) && k < max) begin
         @(negedge clk);
         k++;
      end
      check_eq("a_ack_seen", 32'(ifa.instr_m_ack | ifa.data_m_ack), 32'd1);
   endtask

   task automatic wait_ack_b(input int max, output int k);
      k = 0;
      while (!(ifb.instr_m_ack || ifb.data_m_ack) && k < max) begin
         @(negedge clk);
         k++;
      end
      check_eq("b_ack_seen", 32'(ifb.instr_m_ack | ifb.data_m_ack), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int          k;
      int          busy;
      logic [15:0] cs_m, dack_m, iack_m;

      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      ifa.instr_m_addr = '0; ifa.instr_m_access = 1'b0;
      ifa.data_m_addr = '0; ifa.data_m_data_out = '0; ifa.data_m_access = 1'b0;
      ifa.data_m_wr_en = 1'b0; ifa.data_m_bytesel = 2'b00;
      ifb.instr_m_addr = '0; ifb.instr_m_access = 1'b0;
      ifb.data_m_addr = '0; ifb.data_m_data_out = '0; ifb.data_m_access = 1'b0;
      ifb.data_m_wr_en = 1'b0; ifb.data_m_bytesel = 2'b00;

      mem_a[19'h00010] = 16'hBEEF;
      mem_a[19'h7FFFF] = 16'hFFFF;
      mem_a[19'h00100] = 16'h5A5A;
      mem_a[19'h00001] = 16'h1111;
      mem_a[19'h00002] = 16'h2222;
      mem_b[19'h00055] = 16'hCAFE;
      mem_b[19'h00003] = 16'h0BAD;
      mem_b[19'h00066] = 16'h7777;

      // Reset state
      repeat (2) @(negedge clk);
      check_eq("a_rst_ctl", 32'({ifa.instr_m_ack, ifa.data_m_ack, ifa.ram_cs, ifa.ram_wr_en, ifa.ram_bytesel}), 32'd0);
      check_eq("a_rst_bus", 32'({ifa.ram_addr, ifa.ram_wdata}), 32'd0);
      check_eq("b_rst_ctl", 32'({ifb.instr_m_ack, ifb.data_m_ack, ifb.ram_cs, ifb.ram_wr_en, ifb.ram_bytesel}), 32'd0);
      check_eq("rst_rdata", 32'({ifa.instr_m_data_in, ifb.data_m_data_in}), 32'd0);

      // Idle with no requests
      rst_a_n = 1'b1;
      rst_b_n = 1'b1;
      busy = 0;
      repeat (20) begin
         @(negedge clk);
         if (ifa.ram_cs || ifa.instr_m_ack || ifa.data_m_ack) busy++;
         if (ifb.ram_cs || ifb.instr_m_ack || ifb.data_m_ack) busy++;
      end
      check_eq("idle_quiet", 32'(busy), 32'd0);

      // Instruction read, no wait states
      ifa.instr_m_addr   = 19'h00010;
      ifa.instr_m_access = 1'b1;
      sb_a.push_back(exp_t'{1'b0, 16'hBEEF});
      @(negedge clk);
      check_eq("a_ird_cs", 32'({ifa.ram_cs, ifa.ram_wr_en, ifa.ram_bytesel}), 32'b1011);
      check_eq("a_ird_addr", 32'(ifa.ram_addr), 32'h00010);
      @(negedge clk);
      check_eq("a_ird_ack", 32'({ifa.instr_m_ack, ifa.data_m_ack}), 32'b10);
      check_eq("a_ird_data", 32'(ifa.instr_m_data_in), 32'hBEEF);
      ifa.instr_m_access = 1'b0;
      @(negedge clk);
      check_eq("a_ird_ack_pulse", 32'(ifa.instr_m_ack), 32'd0);

      // Data byte write (high byte only), then read back
      ifa.data_m_addr     = 19'h7FFFF;
      ifa.data_m_data_out = 16'h12AB;
      ifa.data_m_bytesel  = 2'b10;
      ifa.data_m_wr_en    = 1'b1;
      ifa.data_m_access   = 1'b1;
      sb_a.push_back(exp_t'{1'b1, 16'h0000});
      @(negedge clk);
      check_eq("a_wr_strobe", 32'({ifa.ram_cs, ifa.ram_wr_en, ifa.ram_bytesel}), 32'b1110);
      check_eq("a_wr_bus", 32'({ifa.ram_addr, ifa.ram_wdata}), 32'({19'h7FFFF, 16'h12AB}));
      @(negedge clk);
      check_eq("a_wr_ack", 32'({ifa.instr_m_ack, ifa.data_m_ack}), 32'b01);
      ifa.data_m_access = 1'b0;
      ifa.data_m_wr_en  = 1'b0;
      @(negedge clk);
      ifa.data_m_bytesel = 2'b11;
      ifa.data_m_access  = 1'b1;
      sb_a.push_back(exp_t'{1'b1, 16'h12FF});
      wait_ack_a(8, k);
      check_eq("a_rd_latency", 32'(k), 32'd2);
      ifa.data_m_access = 1'b0;
      @(negedge clk);

      // Write with no byte enables: selected and acked, memory unchanged
      ifa.data_m_addr     = 19'h00100;
      ifa.data_m_data_out = 16'hFFFF;
      ifa.data_m_bytesel  = 2'b00;
      ifa.data_m_wr_en    = 1'b1;
      ifa.data_m_access   = 1'b1;
      sb_a.push_back(exp_t'{1'b1, 16'h0000});
      @(negedge clk);
      check_eq("a_wr0_cs", 32'({ifa.ram_cs, ifa.ram_bytesel}), 32'b100);
      wait_ack_a(8, k);
      ifa.data_m_access = 1'b0;
      ifa.data_m_wr_en  = 1'b0;
      @(negedge clk);
      ifa.data_m_bytesel = 2'b11;
      ifa.data_m_access  = 1'b1;
      sb_a.push_back(exp_t'{1'b1, 16'h5A5A});
      wait_ack_a(8, k);
      ifa.data_m_access = 1'b0;
      @(negedge clk);

      // Asynchronous reset during an ack cycle clears every output at once
      ifa.instr_m_addr   = 19'h00010;
      ifa.instr_m_access = 1'b1;
      sb_a.push_back(exp_t'{1'b0, 16'hBEEF});
      repeat (2) @(negedge clk);
      #2 rst_a_n = 1'b0;
      #1;
      check_eq("a_async_rst_ctl", 32'({ifa.instr_m_ack, ifa.data_m_ack, ifa.ram_cs, ifa.ram_wr_en, ifa.ram_bytesel}), 32'd0);
      check_eq("a_async_rst_data", 32'({ifa.instr_m_data_in, ifa.data_m_data_in}), 32'd0);
      ifa.instr_m_access = 1'b0;
      @(negedge clk);
      rst_a_n = 1'b1;
      @(negedge clk);

      // Contention: both masters keep requesting; data wins the first tie
      ifa.instr_m_addr   = 19'h00001;
      ifa.data_m_addr    = 19'h00002;
      ifa.data_m_wr_en   = 1'b0;
      ifa.data_m_bytesel = 2'b11;
      ifa.instr_m_access = 1'b1;
      ifa.data_m_access  = 1'b1;
      sb_a.push_back(exp_t'{1'b1, 16'h2222});
      sb_a.push_back(exp_t'{1'b0, 16'h1111});
      sb_a.push_back(exp_t'{1'b1, 16'h2222});
      sb_a.push_back(exp_t'{1'b0, 16'h1111});
      cs_m = '0; dack_m = '0; iack_m = '0;
      for (int i = 1; i <= 11; i++) begin
         @(negedge clk);
         cs_m   = {cs_m[14:0], ifa.ram_cs};
         dack_m = {dack_m[14:0], ifa.data_m_ack};
         iack_m = {iack_m[14:0], ifa.instr_m_ack};
      end
      ifa.instr_m_access = 1'b0;
      ifa.data_m_access  = 1'b0;
      check_eq("a_rr_cs_cycles", 32'(cs_m), 32'h0492);
      check_eq("a_rr_data_acks", 32'(dack_m), 32'h0208);
      check_eq("a_rr_instr_acks", 32'(iack_m), 32'h0041);
      repeat (2) @(negedge clk);

      // Three wait states: data read
      ifb.data_m_addr    = 19'h00055;
      ifb.data_m_bytesel = 2'b11;
      ifb.data_m_access  = 1'b1;
      sb_b.push_back(exp_t'{1'b1, 16'hCAFE});
      cs_m = '0; dack_m = '0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         cs_m   = {cs_m[14:0], ifb.ram_cs};
         dack_m = {dack_m[14:0], ifb.data_m_ack};
      end
      ifb.data_m_access = 1'b0;
      check_eq("b_ws_cs_cycles", 32'(cs_m), 32'h0010);
      check_eq("b_ws_ack_cycles", 32'(dack_m), 32'h0001);
      @(negedge clk);

      // Three wait states: instruction read
      ifb.instr_m_addr   = 19'h00003;
      ifb.instr_m_access = 1'b1;
      sb_b.push_back(exp_t'{1'b0, 16'h0BAD});
      wait_ack_b(12, k);
      check_eq("b_ird_latency", 32'(k), 32'd5);
      ifb.instr_m_access = 1'b0;
      @(negedge clk);

      // Reset during WAIT aborts; held request restarts after release
      ifb.data_m_addr   = 19'h00066;
      ifb.data_m_access = 1'b1;
      sb_b.push_back(exp_t'{1'b1, 16'h7777});
      repeat (3) @(negedge clk);
      rst_b_n = 1'b0;
      #1;
      check_eq("b_rst_wait_out", 32'({ifb.data_m_ack, ifb.ram_cs}), 32'd0);
      busy = 0;
      repeat (2) begin
         @(negedge clk);
         if (ifb.data_m_ack || ifb.instr_m_ack || ifb.ram_cs) busy++;
      end
      check_eq("b_rst_no_ack", 32'(busy), 32'd0);
      rst_b_n = 1'b1;
      @(negedge clk);
      check_eq("b_restart_cs", 32'({ifb.ram_cs, ifb.ram_addr}), 32'({1'b1, 19'h00066}));
      wait_ack_b(12, k);
      check_eq("b_restart_latency", 32'(k), 32'd4);
      ifb.data_m_access = 1'b0;
      repeat (3) @(negedge clk);

      check_eq("a_sb_drained", 32'(sb_a.size()), 32'd0);
      check_eq("b_sb_drained", 32'(sb_b.size()), 32'd0);
      check_eq("a_rdata_gating", 32'(stray_a), 32'd0);
      check_eq("b_rdata_gating", 32'(stray_b), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
